// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO feeding uart_tx; a push is visible on out_* after one edge.
// Flow control: in_ready drops when full; head byte holds on out_data until out_ready takes it.
module uart_tx_fifo #(
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = DEPTH - 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [7:0]               out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     almost_full
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        empty, full, push, pop;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  assign in_ready    = !full;
  assign out_valid   = !empty;
  assign level       = wr_ptr_q - rd_ptr_q;
  assign almost_full = (level >= (AW+1)'(AFULL_LEVEL));
  assign out_data    = mem_q[rd_ptr_q[AW-1:0]];

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage has no reset; the head slot is never written while occupied.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: fill, drain, streaming across wrap, FWFT latency, flush and async reset.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [4:0] level;
  logic       almost_full;

  int checks   = 0;
  int failures = 0;

  uart_tx_fifo #(.DEPTH(16), .AFULL_LEVEL(12)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .level      (level),
    .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_afull", almost_full, 0);
    reset_n = 1'b1;
    step();

    // Fill with 0x00..0x0F while the consumer stalls
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      chk("fill_ready_pre", in_ready, 1);
      step();
      chk("fill_level", level, 32'(i + 1));
      chk("fill_afull", almost_full, (i + 1 >= 12) ? 1 : 0);
      chk("fill_ready", in_ready, (i + 1 < 16) ? 1 : 0);
    end
    in_data = 8'h55;
    step();
    chk("overfill_level", level, 16);
    chk("overfill_ready", in_ready, 0);
    in_valid = 1'b0;

    // Drain in order
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_valid", out_valid, 1);
      chk("drain_data", out_data, 32'(i));
      step();
      chk("drain_level", level, 32'(15 - i));
    end
    chk("drain_empty", out_valid, 0);
    chk("drain_afull", almost_full, 0);
    out_ready = 1'b0;

    // Bring level to 5, then stream push+pop across the pointer wrap
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h10 + i);
      step();
    end
    chk("stream_start_level", level, 5);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 8'(8'h15 + i);
      chk("stream_data", out_data, 32'(8'h10 + i));
      step();
      chk("stream_level", level, 5);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stream_tail", out_data, 32'(8'h24 + i));
      step();
    end
    chk("stream_empty", out_valid, 0);
    out_ready = 1'b0;

    // First-word-fall-through latency, no bypass
    in_valid = 1'b1;
    in_data  = 8'hA5;
    #1;
    chk("fwft_no_bypass", out_valid, 0);
    step();
    in_valid = 1'b0;
    chk("fwft_valid", out_valid, 1);
    chk("fwft_data", out_data, 8'hA5);
    step();
    step();
    chk("fwft_hold_valid", out_valid, 1);
    chk("fwft_hold_data", out_data, 8'hA5);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("fwft_popped", level, 0);

    // Flush at level 7 with push and pop offered
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h30 + i);
      step();
    end
    chk("flush_pre_level", level, 7);
    flush     = 1'b1;
    in_data   = 8'hEE;
    out_ready = 1'b1;
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("flush_level", level, 0);
    chk("flush_valid", out_valid, 0);
    step();
    chk("flush_dropped", level, 0);

    // Asynchronous reset mid-burst
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h40 + i);
      step();
    end
    chk("arst_pre_level", level, 3);
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_level", level, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_ready", in_ready, 1);
    #2;
    reset_n = 1'b1;
    step();
    chk("arst_after_level", level, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
